pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//   Consumer end of the next-PC path: owns the architectural PC register and the
//   instruction-fetch handshake to instruction memory. Presents {instr, instr_pc}
//   to decode with a valid/ready handshake. On retirement (handshake) it loads the
//   next_pc from the next-PC selector. It also counts retired instructions and traps
//   fetch timeouts and misaligned targets.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC loaded on reset
//   TIMEOUT_CYC  16             max cycles in WAIT before timeout error (>=2)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous reset, active-low
//   next_pc      in   32  next PC from next-PC selector; sampled on retire
//   instr_ready  in   1   decode accepts current instruction
//   instr_valid  out  1   instr/instr_pc valid (HOLD state)
//   instr        out  32  fetched instruction word
//   instr_pc     out  32  PC of instr (= current PC register)
//   imem_req     out  1   fetch request (REQ state)
//   imem_addr    out  32  fetch address (= PC register)
//   imem_gnt     in   1   memory accepted request this cycle
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  read data
//   retire_cnt   out  32  retired-instruction count, wraps 32'hFFFF_FFFF->0
//   fetch_err    out  1   sticky error flag
//   err_cause    out  2   2'b00 none, 2'b01 timeout, 2'b10 misaligned next_pc
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, instr=0, timer=0,
//     retire_cnt=0, err_cause=0. All outputs 0 except imem_addr/instr_pc=RESET_PC.
//   - Outputs decoded from registered state only (Moore); no input->output comb path.
//   - Transitions:
//     IDLE -> REQ  unconditionally, one cycle after reset release.
//     REQ:  imem_req=1. If imem_gnt: -> WAIT, timer<=0. imem_rvalid is ignored in REQ.
//     WAIT: If imem_rvalid: instr<=imem_rdata, -> HOLD.
//           Else timer<=timer+1. If timer==TIMEOUT_CYC-1: -> ERR, err_cause<=01.
//           rvalid on the timeout cycle wins (-> HOLD, no error).
//     HOLD: instr_valid=1. If instr_ready (retire): retire_cnt<=retire_cnt+1.
//           If next_pc[1:0]!=0: -> ERR, err_cause<=10, pc unchanged.
//           Else pc<=next_pc, -> REQ.
//     ERR:  fetch_err=1, all handshake outputs 0. Terminal until rst_n asserted.
//   - Minimum throughput: 3 cycles per instruction (REQ+gnt, WAIT+rvalid, HOLD+ready).
//   - next_pc is sampled only on the retire cycle; it may change freely otherwise.
//   - instr and pc hold stable across HOLD while instr_ready=0 (back-pressure).
//   - A retire that traps as misaligned still increments retire_cnt.
//   - Reset mid-fetch (any state) aborts immediately. A late rvalid after reset is
//     ignored (state IDLE/REQ).
// TESTING
//   1 Reset, gnt=1, rvalid 1 cycle after gnt, ready=1, next_pc=pc+4 -> imem_addr
//     0,4,8 on successive REQs. Each instruction 3 cycles. retire_cnt=3 after 3.
//   2 HOLD with instr_ready=0 for 5 cycles -> instr_valid=1, instr/instr_pc stable.
//     Then ready=1, next_pc=32'h100 -> next imem_addr=32'h100, retire_cnt+1.
//   3 gnt withheld 4 cycles in REQ -> imem_req held 1, imem_addr stable, no timer.
//   4 rvalid never arrives -> ERR after exactly TIMEOUT_CYC (16) WAIT cycles;
//     fetch_err=1, err_cause=01. rvalid on 16th cycle instead -> HOLD, no error.
//   5 Retire with next_pc=32'h0000_0102 -> ERR, err_cause=10, instr_pc unchanged,
//     retire_cnt incremented.
//   6 Assert rst_n=0 during WAIT, preload retire_cnt=32'hFFFF_FFFF case -> all
//     reset values. Separately, wrap: one retire from FFFF_FFFF -> 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Owns the architectural PC and the instruction-fetch handshake to instruction
// memory, hands {instr, instr_pc} to decode, counts retirements and traps fetch
// timeouts and misaligned next-PC targets. All outputs come from flops.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] retire_cnt,
  output logic        fetch_err,
  output logic [1:0]  err_cause
);

  // Timer only has to reach TIMEOUT_CYC-1, so clog2 bits are enough.
  localparam int            TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   retire_cnt_q, retire_cnt_d;
  logic [1:0]    err_cause_q, err_cause_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Next-state and datapath updates; output flags are decoded from the next state
  // so that the registered outputs always match the state they describe.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    timer_d      = timer_q;
    retire_cnt_d = retire_cnt_q;
    err_cause_d  = err_cause_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMER_LAST) begin
            state_d     = S_ERR;
            err_cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          retire_cnt_d = retire_cnt_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            state_d     = S_ERR;
            err_cause_d = CAUSE_MISALIGNED;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
    err_d   = (state_d == S_ERR);
  end

  // State, datapath and output flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      timer_q      <= '0;
      retire_cnt_q <= '0;
      err_cause_q  <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      timer_q      <= timer_d;
      retire_cnt_q <= retire_cnt_d;
      err_cause_q  <= err_cause_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign retire_cnt  = retire_cnt_q;
  assign fetch_err   = err_q;
  assign err_cause   = err_cause_q;

endmodule
